// File: rtl/br_hist_pipe_pkg.sv
// br_hist_pipe_pkg: shared widths and field positions for the branch-history pipeline
package br_hist_pipe_pkg;
  localparam int PC_W_DEF = 32;
  localparam int CNT_W_DEF = 16;
  localparam int PRED_TAKEN_BIT = 0;
endpackage

// File: rtl/br_hist_stage.sv
// br_hist_stage: one valid/pc/pred pipeline register with load, hold and clear
module br_hist_stage #(
  parameter int PC_W = 32,
  parameter int PRED_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic              valid_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [PRED_W-1:0] pred_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [PRED_W-1:0] pred_o
);
  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PRED_W-1:0] pred_q, pred_d;
  always_comb begin
    valid_d = clr ? 1'b0 : load ? valid_i : valid_q;
    pc_d = clr ? '0 : load ? pc_i : pc_q;
    pred_d = clr ? '0 : load ? pred_i : pred_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q <= '0;
      pred_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q <= pc_d;
      pred_q <= pred_d;
    end
  end
  assign valid_o = valid_q;
  assign pc_o = pc_q;
  assign pred_o = pred_q;
endmodule

// File: rtl/br_hist_pipe.sv
// br_hist_pipe: fetch-to-resolve branch PC/prediction pipeline with flush, stall and mispredict stats
module br_hist_pipe
  import br_hist_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W = PC_W_DEF,
  parameter int PRED_W = 1,
  parameter int CNT_W = CNT_W_DEF,
  parameter bit AUTO_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Valid_in,
  input  logic [PC_W-1:0]   PC_in,
  input  logic [PRED_W-1:0] Br_pred_in,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Br_taken,
  output logic              Valid_out,
  output logic [PC_W-1:0]   PC_out,
  output logic [PRED_W-1:0] Br_pred_out,
  output logic              Mispredict,
  output logic [CNT_W-1:0]  Br_cnt,
  output logic [CNT_W-1:0]  Mispred_cnt
);
  logic              st_v    [DEPTH];
  logic [PC_W-1:0]   st_pc   [DEPTH];
  logic [PRED_W-1:0] st_pred [DEPTH];
  logic retire, eff_flush, load;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    logic              v_i;
    logic [PC_W-1:0]   pc_i;
    logic [PRED_W-1:0] pred_i;
    if (s == 0) begin : g_head
      // bubbles enter with zeroed payload so invalid stages never carry stale data
      assign v_i = Valid_in;
      assign pc_i = Valid_in ? PC_in : '0;
      assign pred_i = Valid_in ? Br_pred_in : '0;
    end else begin : g_body
      assign v_i = st_v[s-1];
      assign pc_i = st_pc[s-1];
      assign pred_i = st_pred[s-1];
    end
    br_hist_stage #(.PC_W(PC_W), .PRED_W(PRED_W)) u_stage (
      .clk(clk), .rst(rst), .load(load), .clr(eff_flush),
      .valid_i(v_i), .pc_i(pc_i), .pred_i(pred_i),
      .valid_o(st_v[s]), .pc_o(st_pc[s]), .pred_o(st_pred[s])
    );
  end
  always_comb begin
    retire = Valid_out & ~Stall;
    Mispredict = retire & (Br_taken != Br_pred_out[PRED_TAKEN_BIT]);
    eff_flush = Flush | (AUTO_FLUSH & Mispredict);
    load = ~Stall & ~eff_flush;
    br_cnt_d = (retire && br_cnt_q != {CNT_W{1'b1}}) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
    mis_cnt_d = (Mispredict && mis_cnt_q != {CNT_W{1'b1}}) ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end
  assign Valid_out = st_v[DEPTH-1];
  assign PC_out = st_pc[DEPTH-1];
  assign Br_pred_out = st_pred[DEPTH-1];
  assign Br_cnt = br_cnt_q;
  assign Mispred_cnt = mis_cnt_q;
endmodule

// File: tb/tb_br_hist_pipe.sv
// tb_br_hist_pipe: table, directed and random checks of two br_hist_pipe configurations
module tb_br_hist_pipe;
  logic clk = 1'b0, rst, vi, st, fl, tk;
  logic [31:0] pci, pc0, pc1;
  logic [1:0] pri, pr0, pr1;
  logic vo0, vo1, mp0, mp1;
  logic [15:0] bc0, mc0;
  logic [3:0] bc1, mc1;
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;

  br_hist_pipe #(.DEPTH(2), .PC_W(32), .PRED_W(2), .CNT_W(16), .AUTO_FLUSH(1'b1)) u0 (
    .clk(clk), .rst(rst), .Valid_in(vi), .PC_in(pci), .Br_pred_in(pri), .Stall(st),
    .Flush(fl), .Br_taken(tk), .Valid_out(vo0), .PC_out(pc0), .Br_pred_out(pr0),
    .Mispredict(mp0), .Br_cnt(bc0), .Mispred_cnt(mc0));
  br_hist_pipe #(.DEPTH(4), .PC_W(32), .PRED_W(2), .CNT_W(4), .AUTO_FLUSH(1'b0)) u1 (
    .clk(clk), .rst(rst), .Valid_in(vi), .PC_in(pci), .Br_pred_in(pri), .Stall(st),
    .Flush(fl), .Br_taken(tk), .Valid_out(vo1), .PC_out(pc1), .Br_pred_out(pr1),
    .Mispredict(mp1), .Br_cnt(bc1), .Mispred_cnt(mc1));

  typedef struct packed {logic v; logic [31:0] pc; logic [1:0] pred;} ent_t;
  typedef struct {
    bit v; logic [31:0] pc; logic [1:0] pred; bit st, fl, tk;
    bit evo; logic [31:0] epc; bit emp; int ebc, emc;
  } vec_t;
  ent_t mq[2][$];
  int bc_m[2], mc_m[2];
  vec_t tbl[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      repeat (i == 0 ? 2 : 4) mq[i].push_back('0);
      bc_m[i] = 0;
      mc_m[i] = 0;
    end
  endtask

  // compare both DUTs against the queue model, then advance the model and the clock
  task automatic step();
    #1;
    for (int i = 0; i < 2; i++) begin
      ent_t t = mq[i][mq[i].size()-1];
      bit m = t.v && !st && (tk != t.pred[0]);
      int cmax = (i == 0) ? 65535 : 15;
      chk($sformatf("valid_out%0d", i), i == 0 ? vo0 : vo1, t.v);
      chk($sformatf("pc_out%0d", i), i == 0 ? pc0 : pc1, t.pc);
      chk($sformatf("pred_out%0d", i), i == 0 ? pr0 : pr1, t.pred);
      chk($sformatf("mispredict%0d", i), i == 0 ? mp0 : mp1, m);
      chk($sformatf("br_cnt%0d", i), i == 0 ? bc0 : 16'(bc1), bc_m[i]);
      chk($sformatf("mispred_cnt%0d", i), i == 0 ? mc0 : 16'(mc1), mc_m[i]);
      if (rst) begin
        mq[i].delete();
        repeat (i == 0 ? 2 : 4) mq[i].push_back('0);
        bc_m[i] = 0;
        mc_m[i] = 0;
      end else begin
        if (t.v && !st) begin
          if (bc_m[i] < cmax) bc_m[i]++;
          if (m && mc_m[i] < cmax) mc_m[i]++;
        end
        if (fl || (i == 0 && m)) begin
          for (int k = 0; k < mq[i].size(); k++) mq[i][k] = '0;
        end else if (!st) begin
          void'(mq[i].pop_back());
          mq[i].push_front(vi ? {1'b1, pci, pri} : ent_t'(0));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic row(bit v, logic [31:0] pc, logic [1:0] pred, bit s, bit f, bit t,
                     bit evo, logic [31:0] epc, bit emp, int ebc, int emc);
    tbl.push_back('{v, pc, pred, s, f, t, evo, epc, emp, ebc, emc});
  endtask

  task automatic drive(bit r, bit v, logic [31:0] pc, logic [1:0] pred, bit s, bit f, bit t);
    rst = r; vi = v; pci = pc; pri = pred; st = s; fl = f; tk = t;
  endtask

  initial begin
    int pulses;
    row(1, 32'h100, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    row(1, 32'h104, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    row(1, 32'h108, 1, 0, 0, 1, 1, 32'h100, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 1, 32'h104, 0, 1, 0);
    row(0, 0, 0, 0, 0, 1, 1, 32'h108, 0, 2, 0);
    row(1, 32'h200, 1, 0, 0, 1, 0, 0, 0, 3, 0);
    row(0, 32'hdead, 3, 0, 0, 1, 0, 0, 0, 3, 0);
    row(1, 32'h204, 1, 1, 0, 1, 1, 32'h200, 0, 3, 0);
    row(1, 32'h208, 1, 1, 0, 1, 1, 32'h200, 0, 3, 0);
    row(1, 32'h20c, 1, 1, 0, 1, 1, 32'h200, 0, 3, 0);
    row(0, 0, 0, 0, 0, 1, 1, 32'h200, 0, 3, 0);
    row(1, 32'h300, 1, 0, 0, 1, 0, 0, 0, 4, 0);
    row(0, 0, 0, 0, 0, 1, 0, 0, 0, 4, 0);
    row(0, 0, 0, 0, 0, 0, 1, 32'h300, 1, 4, 0);
    row(1, 32'h304, 1, 0, 0, 1, 0, 0, 0, 5, 1);
    row(1, 32'h308, 1, 0, 0, 1, 0, 0, 0, 5, 1);
    row(1, 32'h30c, 1, 1, 1, 1, 1, 32'h304, 0, 5, 1);
    row(0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 1);
    row(0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset valid_out", {vo0, vo1}, 0);
    chk("reset pc_out", {pc0, pc1}, 0);
    chk("reset counters", {bc0, mc0, bc1, mc1}, 0);
    for (int r = 0; r < tbl.size(); r++) begin
      drive(0, tbl[r].v, tbl[r].pc, tbl[r].pred, tbl[r].st, tbl[r].fl, tbl[r].tk);
      #1;
      chk($sformatf("tbl%0d valid_out", r), vo0, tbl[r].evo);
      chk($sformatf("tbl%0d pc_out", r), pc0, tbl[r].epc);
      chk($sformatf("tbl%0d mispredict", r), mp0, tbl[r].emp);
      chk($sformatf("tbl%0d br_cnt", r), bc0, tbl[r].ebc);
      chk($sformatf("tbl%0d mispred_cnt", r), mc0, tbl[r].emc);
      step();
    end
    // saturation: 30 cycles of always-mispredicting branches after a reset
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      drive(0, 1, 32'h1000 + 32'(c * 4), 1, 0, 0, 0);
      #1;
      pulses += int'(mp1);
      step();
    end
    #1;
    chk("sat mispredict pulses", pulses, 26);
    chk("sat br_cnt1", bc1, 15);
    chk("sat mispred_cnt1", mc1, 15);
    // mid-stream reset with a full DEPTH=4 pipe
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 32'h2000 + 32'(c * 4), 2, 0, 0, 0);
      step();
    end
    #1;
    chk("pre-rst valid_out1", vo1, 1);
    drive(1, 1, 32'h3000, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post-rst valid_out1", vo1, 0);
    chk("post-rst pc_out1", pc1, 0);
    chk("post-rst br_cnt1", bc1, 0);
    chk("post-rst mispred_cnt1", mc1, 0);
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(99) == 0, $urandom_range(9) < 7, $urandom, 2'($urandom),
            $urandom_range(4) == 0, $urandom_range(19) == 0, 1'($urandom));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/br_hist_pipe.md
# br_hist_pipe

Parametrised branch-history pipeline carrying each fetched branch's PC and prediction info from fetch to the resolve stage. It adds valid tracking, stall and flush control, mispredict detection at the tail, and saturating branch/mispredict counters. It sits between the predictor and the EX-stage branch unit, and replaces the fixed 2-deep PC/prediction delay line.

## Interface
- DEPTH, 2: number of pipeline stages, ≥1; equals the fetch-to-resolve distance in cycles.
- PC_W, 32: PC width.
- PRED_W, 1: prediction info width; bit 0 is the predicted-taken flag, upper bits are opaque counter/state data.
- CNT_W, 16: statistics counter width.
- AUTO_FLUSH, 1: 1 makes a detected mispredict flush the pipeline internally.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Valid_in  in  1  the fetch slot holds a branch to track.
- PC_in  in  PC_W  PC of the incoming branch.
- Br_pred_in  in  PRED_W  prediction info of the incoming branch.
- Stall  in  1  freeze every stage.
- Flush  in  1  external flush.
- Br_taken  in  1  actual outcome from the branch unit for the tail entry.
- Valid_out  out  1  the tail stage holds a valid entry.
- PC_out  out  PC_W  tail-stage PC.
- Br_pred_out  out  PRED_W  tail-stage prediction info.
- Mispredict  out  1  combinational tail mispredict flag.
- Br_cnt  out  CNT_W  resolved branches, saturating.
- Mispred_cnt  out  CNT_W  mispredicts, saturating.

## Operation
- Each stage s (0..DEPTH-1) holds valid, pc and pred. Stage 0 loads from the inputs; stage s loads from stage s-1. Stage DEPTH-1 drives the outputs.
- Advance occurs when Stall=0 and no flush applies: every stage shifts by one and the inputs are captured into stage 0, including Valid_in=0 bubbles.
- Stall: with Stall=1 and no flush, all stages hold and inputs are ignored.
- Mispredict = Valid_out & ~Stall & (Br_taken != Br_pred_out[0]).
- Retire event = Valid_out & ~Stall. On each retire, Br_cnt increments and, if Mispredict, Mispred_cnt increments. Both counters saturate at 2^CNT_W−1 and never wrap.
- Effective flush = Flush | (AUTO_FLUSH & Mispredict). On an effective flush, every stage's valid, pc and pred clear to 0 at the next edge. The inputs in that cycle are dropped. Counters still update for the retiring entry.
- Priority: rst > effective flush > Stall > advance. Flush overrides Stall.
- Invalid stages always carry pc=0 and pred=0. A bubble captured via Valid_in=0 zeroes pc and pred regardless of PC_in and Br_pred_in.
- With DEPTH=1 the block is a single register stage; all rules above still apply.

## Timing
- Reset: all stage fields are 0, so Valid_out=0, PC_out=0, Br_pred_out=0, Mispredict=0, Br_cnt=0, Mispred_cnt=0. Reset asserted mid-stream clears everything at that edge; nothing retires in that cycle.
- Latency: an entry captured at edge k appears on the outputs after edge k+DEPTH−1 with no stalls, i.e. it is visible during the cycle following its DEPTH-th capture edge. Each stalled cycle adds exactly one cycle.
- Throughput is one entry per unstalled cycle.
- Mispredict and the outputs are valid in the same cycle. Counters reflect a retire one edge later.
- Flush in cycle c: Valid_out=0 during cycle c+1 through at least cycle c+DEPTH, until new entries arrive.
- Flush and Stall asserted together: the flush happens and nothing is held.
- A counter at saturation stays there; Br_cnt and Mispred_cnt saturate independently.

## Structure
- A shared package holds the default widths (PC_W and CNT_W defaults) and the bit index of the predicted-taken flag within the prediction field.
- One natural sub-module: br_hist_stage, a single valid/pc/pred register with load, hold and clear controls, instantiated DEPTH times via generate.
- The counters and mispredict logic live in the top module.

## Test plan
- Reset then stream: DEPTH=2, PC_in=0x100/0x104/0x108 with Valid_in=1 on consecutive cycles → PC_out shows 0x100/0x104/0x108 two cycles later, Valid_out=1, Br_cnt counts 1, 2, 3.
- Stall: assert Stall for 3 cycles while 0x200 is at the tail → PC_out holds 0x200, Br_cnt unchanged, inputs during the stall lost; 0x200 retires on the first unstalled cycle.
- Mispredict with AUTO_FLUSH=1: tail pred=1, Br_taken=0 → Mispredict=1, Mispred_cnt+1, then Valid_out=0 for the next 2 cycles and PC_out=0.
- External Flush together with Stall and Valid_in=1 (PC_in=0x300) → the pipe empties, 0x300 never appears, and Flush wins over Stall.
- Saturation: CNT_W=4 with 20 mispredicting retires (AUTO_FLUSH=0) → Br_cnt and Mispred_cnt stop at 15; Mispredict still pulses each retire.
- Mid-stream rst with DEPTH=4 and a full pipe → all outputs and counters are 0 on the next cycle, and no retire is counted in the reset cycle.
